// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and the parity helper,
// common to the transmit serializer and the future receive deserializer.
package uart_pkg;

   localparam int DATA_BITS     = 8;
   localparam int BIT_IDX_W     = $clog2(DATA_BITS);
   localparam int DIV_W_DEFAULT = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } uart_state_e;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..div while enabled and flags the last cycle of each bit.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_r;

   assign tick = en && (cnt_r == div);

   // Count within the current bit; wrap to zero on each bit boundary.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_r <= {DIV_W{1'b0}};
      end else if (tick) begin
         cnt_r <= {DIV_W{1'b0}};
      end else if (en) begin
         cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit stage: pops bytes from the TX FIFO and serialises start/data/[parity]/stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_en,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic                 stop2,
   input  logic [DATA_BITS-1:0] fifo_data,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   uart_state_e          state_r;
   logic [DATA_BITS-1:0] shreg_r;
   logic [BIT_IDX_W-1:0] bit_idx_r;
   logic [DIV_W-1:0]     div_lat_r;
   logic                 stop2_lat_r;
   logic                 stop_idx_r;
   logic                 start_s;
   logic                 tick_s;
`ifdef UART_TX_PARITY_EN
   logic                 par_r;
`endif

   assign start_s = (state_r == S_IDLE) && tx_en && !fifo_empty;

   uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_s),
      .en   (state_r != S_IDLE),
      .div  (div_lat_r),
      .tick (tick_s)
   );

   // Frame sequencer; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         shreg_r     <= {DATA_BITS{1'b0}};
         bit_idx_r   <= {BIT_IDX_W{1'b0}};
         div_lat_r   <= {DIV_W{1'b0}};
         stop2_lat_r <= 1'b0;
         stop_idx_r  <= 1'b0;
         fifo_rd_en  <= 1'b0;
         tx          <= 1'b1;
         busy        <= 1'b0;
         tx_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_r       <= 1'b0;
`endif
      end else begin
         fifo_rd_en <= 1'b0;
         tx_done    <= 1'b0;
         case (state_r)
            S_IDLE: begin
               tx <= 1'b1;
               if (start_s) begin
                  shreg_r     <= fifo_data;
                  div_lat_r   <= baud_div;
                  stop2_lat_r <= stop2;
                  fifo_rd_en  <= 1'b1;
                  tx          <= 1'b0;
                  busy        <= 1'b1;
                  state_r     <= S_START;
`ifdef UART_TX_PARITY_EN
                  par_r       <= even_parity(fifo_data);
`endif
               end
            end
            S_START: begin
               if (tick_s) begin
                  tx        <= shreg_r[0];
                  bit_idx_r <= {BIT_IDX_W{1'b0}};
                  state_r   <= S_DATA;
               end
            end
            S_DATA: begin
               if (tick_s) begin
                  if (bit_idx_r == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     tx         <= par_r;
                     state_r    <= S_PARITY;
`else
                     tx         <= 1'b1;
                     stop_idx_r <= 1'b0;
                     state_r    <= S_STOP;
`endif
                  end else begin
                     shreg_r   <= {1'b0, shreg_r[DATA_BITS-1:1]};
                     tx        <= shreg_r[1];
                     bit_idx_r <= bit_idx_r + {{(BIT_IDX_W-1){1'b0}}, 1'b1};
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (tick_s) begin
                  tx         <= 1'b1;
                  stop_idx_r <= 1'b0;
                  state_r    <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (tick_s) begin
                  // stop_idx_r equals the latched stop2 only on the final stop bit
                  if (stop_idx_r == stop2_lat_r) begin
                     tx_done <= 1'b1;
                     busy    <= 1'b0;
                     state_r <= S_IDLE;
                  end else begin
                     stop_idx_r <= 1'b1;
                  end
               end
            end
            default: begin
               tx      <= 1'b1;
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a queue-based FIFO model feeds the DUT and
// a per-cycle expected waveform is built from the frame rules (honours UART_TX_PARITY_EN).
module tb_uart_tx_serializer;

   localparam int DIV_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             tx_en;
   logic [DIV_W-1:0] baud_div;
   logic             stop2;
   logic [7:0]       fifo_data;
   logic             fifo_empty;
   logic             fifo_rd_en;
   logic             tx;
   logic             busy;
   logic             tx_done;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] fifo_q[$];
   logic [7:0] pend_q[$];
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   uart_tx_serializer #(.DIV_W(DIV_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_en      (tx_en),
      .baud_div   (baud_div),
      .stop2      (stop2),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   task automatic drive_fifo();
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
   endtask

   // Advance to the next falling edge; the FIFO model honours a pop strobe seen there.
   task automatic step();
      @(negedge clk);
      if (fifo_rd_en && fifo_q.size() != 0) void'(fifo_q.pop_front());
      drive_fifo();
   endtask

   task automatic check_idle(input string name, input int idx);
      logic [3:0] got;
      got = {tx, busy, fifo_rd_en, tx_done};
      n_checks++;
      if (got !== 4'b1000)
         $display("FAIL %s cycle %0d: {tx,busy,rd_en,done} got %b expected 1000", name, idx, got);
      else
         n_pass++;
   endtask

   // Expected {tx,busy,fifo_rd_en,tx_done} per cycle, from the frame format.
   task automatic build_expected(input int div, input logic s2, input int nframes);
      logic       bits[$];
      logic [7:0] b;
      exp_q.delete();
      for (int f = 0; f < nframes; f++) begin
         b = pend_q[f];
         bits.delete();
         bits.push_back(1'b0);
         for (int k = 0; k < 8; k++) bits.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
         bits.push_back(^b);
`endif
         bits.push_back(1'b1);
         if (s2) bits.push_back(1'b1);
         for (int j = 0; j < bits.size(); j++)
            for (int c = 0; c <= div; c++)
               exp_q.push_back({bits[j], 1'b1, (j == 0 && c == 0), 1'b0});
         exp_q.push_back(4'b1001);
      end
      for (int k = 0; k < 3; k++) exp_q.push_back(4'b1000);
   endtask

   task automatic run_frames(input string name, input int div, input logic s2, input int drop_at);
      int         nframes;
      int         remain;
      logic [3:0] got;
      nframes = (drop_at >= 0) ? 1 : pend_q.size();
      remain  = pend_q.size() - nframes;
      build_expected(div, s2, nframes);
      step();
      baud_div = DIV_W'(div);
      stop2    = s2;
      foreach (pend_q[k]) fifo_q.push_back(pend_q[k]);
      drive_fifo();
      tx_en = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
         step();
         got = {tx, busy, fifo_rd_en, tx_done};
         n_checks++;
         if (got !== exp_q[i])
            $display("FAIL %s cycle %0d: {tx,busy,rd_en,done} got %b expected %b", name, i, got, exp_q[i]);
         else
            n_pass++;
         if (i == drop_at) begin
            tx_en    = 1'b0;
            baud_div = baud_div + 16'd3;
            stop2    = ~stop2;
         end
      end
      n_checks++;
      if (fifo_q.size() != remain)
         $display("FAIL %s fifo_left: got %0d expected %0d", name, fifo_q.size(), remain);
      else
         n_pass++;
      tx_en = 1'b0;
      fifo_q.delete();
      pend_q.delete();
      drive_fifo();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      check_idle("reset_idle", 0);
      rst = 1'b0;
      step();
      fifo_q.push_back(8'hC3);
      drive_fifo();
      baud_div = 16'd2;
      stop2    = 1'b0;
      tx_en    = 1'b1;
      repeat (8) step();
      n_checks++;
      if (busy !== 1'b1 || fifo_q.size() != 0)
         $display("FAIL reset_midframe_busy: busy %b fifo %0d expected busy 1 fifo 0", busy, fifo_q.size());
      else
         n_pass++;
      tx_en = 1'b0;
      rst   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_idle("reset_during", i);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         check_idle("reset_after", i);
      end
   endtask

   task automatic test_single();
      pend_q.push_back(8'hA5);
      run_frames("single_a5", 3, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      pend_q.push_back(8'h00);
      pend_q.push_back(8'hFF);
      run_frames("b2b_00_ff", 0, 1'b0, -1);
   endtask

   task automatic test_stop2();
      pend_q.push_back(8'h55);
      run_frames("stop2_55", 1, 1'b1, -1);
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      pend_q.push_back(8'h07);
      pend_q.push_back(8'h03);
      run_frames("parity_07_03", 1, 1'b0, -1);
   endtask
`endif

   task automatic test_random();
      int n;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 3);
         for (int k = 0; k < n; k++) pend_q.push_back(8'($urandom_range(0, 255)));
         run_frames("random", $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
      end
   endtask

   task automatic test_idle_hold();
      tx_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         check_idle("empty_hold", i);
      end
      tx_en = 1'b0;
      fifo_q.push_back(8'h3C);
      drive_fifo();
      for (int i = 0; i < 100; i++) begin
         step();
         check_idle("txen_low_hold", i);
      end
      fifo_q.delete();
      drive_fifo();
   endtask

   task automatic test_tx_en_drop();
      pend_q.push_back(8'($urandom_range(0, 255)));
      pend_q.push_back(8'($urandom_range(0, 255)));
      run_frames("tx_en_drop", 2, 1'b0, 2);
   endtask

   initial begin
      rst      = 1'b1;
      tx_en    = 1'b0;
      baud_div = 16'd0;
      stop2    = 1'b0;
      drive_fifo();
      test_reset();
      test_single();
      test_back_to_back();
      test_stop2();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_random();
      test_idle_hold();
      test_tx_en_drop();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
